apb_splitter_tmo: RTL and testbench

APB_SPLITTER_TMO -- requirements
Module: apb_splitter_tmo

---
 rtl/apb_splitter_tmo_pkg.sv | 10 +
 rtl/apb_splitter_tmo_onehot_mux.sv | 19 +
 rtl/apb_splitter_tmo.sv | 180 ++++++++++++++++++
 tb/tb_apb_splitter_tmo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_splitter_tmo_pkg.sv
// apb_splitter_tmo_pkg: shared helpers for the APB splitter.
// Provides the slave-index width function used for tmo_slave.
package apb_splitter_tmo_pkg;

  // Index width for n slaves, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_splitter_tmo_onehot_mux.sv
// onehot_mux: AND-OR selector for a one-hot (or zero) select.
// Ports: sel [N], din [N*W] packed lanes, dout [W] (zero if no select).
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/apb_splitter_tmo.sv
// apb_splitter_tmo: 1-to-N APB splitter, priority address decode,
// decode-error response and per-access timeout with sticky status.
// Ports: clk, rst_n (sync, active-low); apbs_* upstream APB slave;
// apbm_* N downstream APB masters (packed); tmo_clr/tmo_flag/tmo_slave.
module apb_splitter_tmo
  import apb_splitter_tmo_pkg::*;
#(
  parameter int W_ADDR   = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 2,
  parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP  = 32'h0000_4000,
  parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK = 32'hc000_c000,
  parameter int TIMEOUT  = 256,
  parameter int W_TMO    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [W_ADDR-1:0]            apbs_paddr,
  input  logic                         apbs_psel,
  input  logic                         apbs_penable,
  input  logic                         apbs_pwrite,
  input  logic [W_DATA-1:0]            apbs_pwdata,
  output logic                         apbs_pready,
  output logic [W_DATA-1:0]            apbs_prdata,
  output logic                         apbs_pslverr,
  output logic [N_SLAVES*W_ADDR-1:0]   apbm_paddr,
  output logic [N_SLAVES-1:0]          apbm_psel,
  output logic [N_SLAVES-1:0]          apbm_penable,
  output logic [N_SLAVES-1:0]          apbm_pwrite,
  output logic [N_SLAVES*W_DATA-1:0]   apbm_pwdata,
  input  logic [N_SLAVES-1:0]          apbm_pready,
  input  logic [N_SLAVES-1:0]          apbm_pslverr,
  input  logic [N_SLAVES*W_DATA-1:0]   apbm_prdata,
  input  logic                         tmo_clr,
  output logic                         tmo_flag,
  output logic [idx_w(N_SLAVES)-1:0]   tmo_slave
);

  localparam int W_IDX = idx_w(N_SLAVES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DECERR = 2'd2;

  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [W_TMO-1:0] TMO_LAST =
    W_TMO'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [N_SLAVES-1:0] sel_q;
  logic [N_SLAVES-1:0] dec;
  logic [W_TMO-1:0]    cnt_q;
  logic                flag_q;
  logic [W_IDX-1:0]    slv_q;
  logic [W_IDX-1:0]    sel_idx;
  logic [W_DATA-1:0]   mux_rdata;
  logic                sel_rdy;
  logic                sel_err;
  logic                setup;
  logic                tmo_fire;

  assign apbm_paddr  = {N_SLAVES{apbs_paddr}};
  assign apbm_pwdata = {N_SLAVES{apbs_pwdata}};
  assign tmo_flag    = flag_q;
  assign tmo_slave   = slv_q;

  // Walk from the top index down so the lowest hit overwrites.
  always_comb begin
    dec = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((apbs_paddr & ADDR_MASK[i*W_ADDR +: W_ADDR])
          == ADDR_MAP[i*W_ADDR +: W_ADDR]) begin
        dec    = '0;
        dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) sel_idx = W_IDX'(i);
    end
  end

  onehot_mux #(
    .N (N_SLAVES),
    .W (W_DATA)
  ) u_rdata_mux (
    .sel  (sel_q),
    .din  (apbm_prdata),
    .dout (mux_rdata)
  );

  assign sel_rdy = |(sel_q & apbm_pready);
  assign sel_err = |(sel_q & apbm_pslverr);
  assign setup   = apbs_psel && !apbs_penable;

  // A slave answering on the last allowed cycle wins over the timeout.
  assign tmo_fire = TMO_EN
                 && (state_q == S_ACCESS)
                 && apbs_psel
                 && !sel_rdy
                 && (cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      slv_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && setup) begin
        sel_q <= dec;
      end else if (state_d == S_IDLE) begin
        sel_q <= '0;
      end
      if (TMO_EN && state_q == S_ACCESS && state_d == S_ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (tmo_fire) begin
        flag_q <= 1'b1;
        slv_q  <= sel_idx;
      end else if (tmo_clr) begin
        flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) state_d = (|dec) ? S_ACCESS : S_DECERR;
      end
      S_ACCESS: begin
        if (!apbs_psel || sel_rdy || tmo_fire) state_d = S_IDLE;
      end
      S_DECERR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are held at their idle values while rst_n is low so an
  // interrupted transfer never reports an error.
  always_comb begin
    apbm_psel    = '0;
    apbm_penable = '0;
    apbm_pwrite  = '0;
    apbs_pready  = 1'b1;
    apbs_pslverr = 1'b0;
    apbs_prdata  = '0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          apbm_psel   = dec & {N_SLAVES{apbs_psel}};
          apbm_pwrite = dec & {N_SLAVES{apbs_psel & apbs_pwrite}};
        end
        S_ACCESS: begin
          apbm_psel    = sel_q & {N_SLAVES{apbs_psel}};
          apbm_penable = sel_q & {N_SLAVES{apbs_penable}};
          apbm_pwrite  = sel_q & {N_SLAVES{apbs_pwrite}};
          apbs_pready  = sel_rdy | tmo_fire;
          apbs_pslverr = sel_err | tmo_fire;
          apbs_prdata  = mux_rdata;
        end
        S_DECERR: begin
          apbs_pslverr = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_splitter_tmo.sv
// tb_apb_splitter_tmo: directed bench for apb_splitter_tmo, TIMEOUT=8.
// Second instance checks priority when both slaves map to 0x0000.
module tb_apb_splitter_tmo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] m_paddr;
  logic [1:0]  m_psel, m_penable, m_pwrite;
  logic [63:0] m_pwdata;
  logic [1:0]  m_pready, m_pslverr;
  logic [63:0] m_prdata;
  logic        tmo_clr, tmo_flag;
  logic [0:0]  tmo_slave;

  logic [15:0] b_paddr;
  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_pwdata;
  logic        b_pready, b_pslverr;
  logic [31:0] b_prdata;
  logic [31:0] bm_paddr;
  logic [1:0]  bm_psel, bm_penable, bm_pwrite;
  logic [63:0] bm_pwdata;
  logic [1:0]  bm_pready, bm_pslverr;
  logic [63:0] bm_prdata;
  logic        b_clr, b_flag;
  logic [0:0]  b_slave;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_splitter_tmo #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_paddr(paddr), .apbs_psel(psel), .apbs_penable(penable),
    .apbs_pwrite(pwrite), .apbs_pwdata(pwdata),
    .apbs_pready(pready), .apbs_prdata(prdata), .apbs_pslverr(pslverr),
    .apbm_paddr(m_paddr), .apbm_psel(m_psel), .apbm_penable(m_penable),
    .apbm_pwrite(m_pwrite), .apbm_pwdata(m_pwdata),
    .apbm_pready(m_pready), .apbm_pslverr(m_pslverr),
    .apbm_prdata(m_prdata),
    .tmo_clr(tmo_clr), .tmo_flag(tmo_flag), .tmo_slave(tmo_slave)
  );

  apb_splitter_tmo #(.ADDR_MAP(32'h0000_0000), .TIMEOUT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .apbs_paddr(b_paddr), .apbs_psel(b_psel), .apbs_penable(b_penable),
    .apbs_pwrite(b_pwrite), .apbs_pwdata(b_pwdata),
    .apbs_pready(b_pready), .apbs_prdata(b_prdata), .apbs_pslverr(b_pslverr),
    .apbm_paddr(bm_paddr), .apbm_psel(bm_psel), .apbm_penable(bm_penable),
    .apbm_pwrite(bm_pwrite), .apbm_pwdata(bm_pwdata),
    .apbm_pready(bm_pready), .apbm_pslverr(bm_pslverr),
    .apbm_prdata(bm_prdata),
    .tmo_clr(b_clr), .tmo_flag(b_flag), .tmo_slave(b_slave)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [15:0] a, input logic w,
                       input logic [31:0] d);
    psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = d;
    m_pready = 2'b00;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    m_pready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tmo_clr = 1'b0;
    paddr = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    b_paddr = 16'h0000; b_psel = 1'b1; b_penable = 1'b0;
    b_pwrite = 1'b0; b_pwdata = '0; b_clr = 1'b0;
    bm_pready = 2'b11; bm_pslverr = '0; bm_prdata = '0;

    step(); step(); #1;
    chk("rst_pready", pready, 1);
    chk("rst_psel", m_psel, 2'b00);
    chk("rst_penable", m_penable, 2'b00);
    chk("rst_flag", tmo_flag, 0);
    chk("rst_slave", tmo_slave, 0);
    step(); rst_n = 1'b1; #1;
    chk("prio_both_hit", bm_psel, 2'b01);

    // read 0x4010, slave0 with two wait states
    step(); setup(16'h4010, 1'b0, 32'h0); #1;
    chk("t1_setup_psel", m_psel, 2'b01);
    chk("t1_setup_pen", m_penable, 2'b00);
    chk("t1_paddr", m_paddr, 32'h4010_4010);
    step(); penable = 1'b1; #1;
    chk("t1_wait_rdy", pready, 0);
    chk("t1_pen", m_penable, 2'b01);
    step();
    step(); m_pready = 2'b01; m_prdata = 64'h1234_5678_dead_beef; #1;
    chk("t1_rdy", pready, 1);
    chk("t1_rdata", prdata, 32'hdead_beef);
    chk("t1_err", pslverr, 0);
    step(); idle(); #1;
    chk("t1_idle_rdata", prdata, 0);

    // write slave1 then read slave0 back to back
    step(); setup(16'h0020, 1'b1, 32'ha5a5_a5a5); #1;
    chk("t2_psel1", m_psel, 2'b10);
    chk("t2_wdata", m_pwdata, 64'ha5a5_a5a5_a5a5_a5a5);
    step(); penable = 1'b1; m_pready = 2'b10; #1;
    chk("t2_pwrite", m_pwrite, 2'b10);
    chk("t2_rdy", pready, 1);
    step(); setup(16'h4000, 1'b0, 32'h0); #1;
    chk("t2_b2b_psel", m_psel, 2'b01);
    step(); penable = 1'b1; m_pready = 2'b01;
    m_prdata = 64'h0000_0000_0bad_f00d; #1;
    chk("t2_rdata", prdata, 32'h0bad_f00d);
    step(); idle();

    // unmapped 0x8000
    step(); setup(16'h8000, 1'b0, 32'h0); #1;
    chk("t3_setup_psel", m_psel, 2'b00);
    step(); penable = 1'b1; #1;
    chk("t3_rdy", pready, 1);
    chk("t3_err", pslverr, 1);
    chk("t3_rdata", prdata, 0);
    chk("t3_psel", m_psel, 2'b00);
    step(); idle(); #1;
    chk("t3_idle_err", pslverr, 0);

    // slave1 never ready: timeout on 8th access cycle
    step(); setup(16'h0000, 1'b0, 32'h0);
    step(); penable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      #1;
      if (k == 7) chk("t4_wait7", pready, 0);
      step();
    end
    #1;
    chk("t4_tmo_rdy", pready, 1);
    chk("t4_tmo_err", pslverr, 1);
    chk("t4_flag_pre", tmo_flag, 0);
    step(); idle(); #1;
    chk("t4_flag", tmo_flag, 1);
    chk("t4_slave", tmo_slave, 1);
    chk("t4_psel", m_psel, 2'b00);

    tmo_clr = 1'b1;
    step(); tmo_clr = 1'b0; #1;
    chk("clr_flag", tmo_flag, 0);

    // slave0 ready on the cycle the timeout would fire
    step(); setup(16'h4000, 1'b0, 32'h0);
    step(); penable = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    m_pready = 2'b01; #1;
    chk("t5_rdy", pready, 1);
    chk("t5_err", pslverr, 0);
    step(); idle(); #1;
    chk("t5_flag", tmo_flag, 0);

    // psel dropped mid-access
    step(); setup(16'h4000, 1'b0, 32'h0);
    step(); penable = 1'b1;
    step(); idle();
    step(); setup(16'h0000, 1'b0, 32'h0); #1;
    chk("t6_after_drop", m_psel, 2'b10);
    step(); penable = 1'b1; m_pready = 2'b10;
    step(); idle(); #1;
    chk("t6_flag", tmo_flag, 0);

    // timeout on slave0 with tmo_clr in the same cycle
    step(); setup(16'h4000, 1'b0, 32'h0);
    step(); penable = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    tmo_clr = 1'b1; #1;
    chk("t7_err", pslverr, 1);
    step(); tmo_clr = 1'b0; idle(); #1;
    chk("t7_flag", tmo_flag, 1);
    chk("t7_slave", tmo_slave, 0);

    // reset in the 3rd access cycle
    step(); setup(16'h0000, 1'b0, 32'h0);
    step(); penable = 1'b1;
    step();
    step(); rst_n = 1'b0; #1;
    chk("t8_err", pslverr, 0);
    chk("t8_rdy", pready, 1);
    chk("t8_psel", m_psel, 2'b00);
    step(); rst_n = 1'b1; idle(); #1;
    chk("t8_flag", tmo_flag, 0);
    chk("t8_slave", tmo_slave, 0);
    chk("t8_pen", m_penable, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
